cosim_commit_arbiter: RTL and testbench
=======================================

Name: cosim_commit_arbiter

Overview:
- Collects per-hart RTL commit records for Spike lock-step cosimulation.
- Buffers each hart's records in its own FIFO and round-robins them onto a single registered checker port.
- The checker side (the DPI `step` / `get_spike_commit_info` caller) consumes one record per handshake and compares it against Spike.
- Generalises single-hart commit capture to NUM_HARTS channels with configurable depth, per-hart sequence numbering, and overflow accounting.

Parameters:
- NUM_HARTS, 2, number of commit channels (1..16).
- DEPTH, 8, per-hart FIFO entries; power of two, >= 2.
- XLEN, 64, width of pc and data fields.
- SEQ_W, 32, per-hart sequence number width.
- DROP_W, 16, per-hart saturating drop-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- commit_valid_i  in  NUM_HARTS  per-hart commit strobe; the source never stalls.
- commit_i  in  NUM_HARTS x commit_in_t  per-hart record: pc, ins[31:0], dst[4:0], wr_valid, data, xcpt, cause[XLEN-1:0].
- chk_valid_o  out  1  checker record valid.
- chk_ready_i  in  1  checker accepts record.
- chk_hart_o  out  $clog2(NUM_HARTS) (min 1)  hart id of the presented record.
- chk_rec_o  out  commit_entry_t  record plus its seq number.
- ovf_clr_i  in  1  synchronous clear of all overflow flags and drop counters.
- overflow_o  out  NUM_HARTS  sticky: the hart dropped at least one record.
- drop_cnt_o  out  NUM_HARTS x DROP_W  saturating dropped-record count per hart.
- occupancy_o  out  NUM_HARTS x ($clog2(DEPTH)+1)  entries held in each FIFO.

Behaviour:
- Reset (async assert, sync deassert by clk domain):
  - All FIFOs empty; seq counters 0.
  - chk_valid_o=0, chk_hart_o=0, chk_rec_o=0.
  - overflow_o=0, drop_cnt_o=0, occupancy_o=0.
  - Round-robin pointer = hart 0.
  - Reset mid-operation discards every buffered record and the output register contents.
- Push:
  - commit_valid_i[h]=1 is accepted if FIFO h is not full, or if it is full and is being popped in the same cycle.
  - The stored entry carries seq = seq_cnt[h].
  - seq_cnt[h] increments (mod 2^SEQ_W) on every commit_valid_i[h], accepted or dropped. A drop therefore shows up at the checker as a seq gap.
- Drop:
  - Occurs when FIFO h is full and not popped this cycle.
  - overflow_o[h] set; drop_cnt_o[h] += 1, saturating at all-ones.
  - If ovf_clr_i and a drop coincide, the drop wins: overflow=1, count=1.
- Output register:
  - Loads when (!chk_valid_o || chk_ready_i) and at least one FIFO is non-empty. The selected FIFO is popped in that same cycle.
  - If no FIFO is non-empty at that point, chk_valid_o goes to 0.
  - While chk_valid_o && !chk_ready_i, chk_hart_o and chk_rec_o hold stable.
- Arbitration:
  - Round robin starting at the pointer; the first non-empty hart wins.
  - After a grant, the pointer = granted hart + 1 (mod NUM_HARTS).
  - NUM_HARTS=1 degenerates to a plain FIFO plus output register.
- Latency: a record pushed in cycle N (into an empty system with the output register free) appears on chk_valid_o at cycle N+1. There is no FIFO bypass.
- Throughput: one record per cycle on the checker port under continuous chk_ready_i.
- Ordering: per-hart order is preserved strictly; no ordering guarantee exists across harts.
- occupancy_o is the registered FIFO count. It excludes the record held in the output register.
- Pointers: FIFO pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full = MSBs differ and lower bits equal; empty = equal pointers.

Decomposition:
- Package cosim_pkg, holding:
  - commit_in_t struct (pc, ins, dst, wr_valid, data, xcpt, cause);
  - commit_entry_t struct (commit_in_t + seq);
  - localparams for default XLEN/SEQ_W.
  - It shares field meanings with the DPI core_commit_info_t so the checker copies fields one-to-one.
- Sub-module cosim_commit_fifo:
  - One per hart, generated.
  - Ports: push/pop/full/empty/count/head.
  - Async reset.
- Arbiter, drop accounting and the output register live in the top.

Test Plan:
- Single hart 0 commit, pc=0x8000_0000, chk_ready_i=1 -> chk_valid_o=1 one cycle later, chk_hart_o=0, seq=0, occupancy back to 0.
- Harts 0 and 1 each push 3 records on the same cycles, ready held 1 -> checker sees hart order 0,1,0,1,0,1 with seq 0,0,1,1,2,2.
- DEPTH=8, chk_ready_i=0, hart 1 pushes 10 records -> 8 FIFO entries plus 1 in the output register. The 10th record is dropped (overflow_o[1]=1, drop_cnt_o[1]=1). After releasing ready, seqs 0..8 arrive and seq 9 is missing.
- Full FIFO with a pop and push in the same cycle -> push accepted, no drop, occupancy unchanged at 8.
- chk_ready_i toggled 1/0 every cycle with continuous pushes -> chk_rec_o stable across every stalled cycle, no record lost or duplicated.
- rst asserted mid-burst with 5 entries buffered -> all outputs 0 immediately. After release, the next commit on hart 0 yields seq=0.

Source files
------------

// File: rtl/cosim_pkg.sv
// Shared types for per-hart commit capture in Spike lock-step cosimulation.
// Field meanings match the DPI commit-info record so the checker can copy
// each field one-to-one.
package cosim_pkg;

   localparam int COSIM_XLEN  = 64;
   localparam int COSIM_SEQ_W = 32;

   typedef struct packed {
      logic [COSIM_XLEN-1:0] pc;
      logic [31:0]           ins;
      logic [4:0]            dst;
      logic                  wr_valid;
      logic [COSIM_XLEN-1:0] data;
      logic                  xcpt;
      logic [COSIM_XLEN-1:0] cause;
   } commit_in_t;

   typedef struct packed {
      commit_in_t             rec;
      logic [COSIM_SEQ_W-1:0] seq;
   } commit_entry_t;

   // Hart-id width; a single hart still gets a 1-bit id field.
   function automatic int hart_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cosim_commit_fifo.sv
// Per-hart commit FIFO. Pointers carry an extra wrap bit so full and empty
// are distinguished without a separate counter. The owner only pushes when
// the FIFO is not full or is being popped in the same cycle, and only pops
// when it is non-empty.
module cosim_commit_fifo
   import cosim_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  commit_entry_t entry_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [PW-1:0] count_o,
   output commit_entry_t head_o
);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   commit_entry_t r_mem [DEPTH];

   // Pointer advance; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push_i) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (pop_i)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= entry_i;
   end

   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign count_o = r_wr_ptr - r_rd_ptr;
   assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/cosim_commit_arbiter.sv
// Collects per-hart commit records, buffers them per hart and round-robins
// them onto one registered checker port. Each record carries a per-hart
// sequence number that advances on every commit strobe, so a dropped record
// appears at the checker as a sequence gap.
module cosim_commit_arbiter
   import cosim_pkg::*;
#(
   parameter  int NUM_HARTS = 2,
   parameter  int DEPTH     = 8,
   parameter  int XLEN      = COSIM_XLEN,
   parameter  int SEQ_W     = COSIM_SEQ_W,
   parameter  int DROP_W    = 16,
   localparam int HART_W    = hart_w(NUM_HARTS),
   localparam int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_HARTS-1:0]                commit_valid_i,
   input  commit_in_t [NUM_HARTS-1:0]          commit_i,
   output logic                                chk_valid_o,
   input  logic                                chk_ready_i,
   output logic [HART_W-1:0]                   chk_hart_o,
   output commit_entry_t                       chk_rec_o,
   input  logic                                ovf_clr_i,
   output logic [NUM_HARTS-1:0]                overflow_o,
   output logic [NUM_HARTS-1:0][DROP_W-1:0]    drop_cnt_o,
   output logic [NUM_HARTS-1:0][CNT_W-1:0]     occupancy_o
);

   // Record layout is fixed by the package; reject mismatched overrides.
   if (XLEN != COSIM_XLEN || SEQ_W != COSIM_SEQ_W) begin : g_bad_width
      $error("XLEN/SEQ_W must match cosim_pkg record layout");
   end
   if (NUM_HARTS < 1 || NUM_HARTS > 16) begin : g_bad_harts
      $error("NUM_HARTS must be 1..16");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end

   logic [NUM_HARTS-1:0]  w_full;
   logic [NUM_HARTS-1:0]  w_empty;
   logic [NUM_HARTS-1:0]  w_push;
   logic [NUM_HARTS-1:0]  w_pop;
   logic [NUM_HARTS-1:0]  w_drop;
   commit_entry_t         w_entry [NUM_HARTS];
   commit_entry_t         w_head  [NUM_HARTS];
   logic                  w_any;
   logic                  w_load;
   logic [HART_W-1:0]     w_grant;

   logic [SEQ_W-1:0]      r_seq_cnt [NUM_HARTS];
   logic [HART_W-1:0]     r_rr_ptr;
   logic                  r_chk_valid;
   logic [HART_W-1:0]     r_chk_hart;
   commit_entry_t         r_chk_rec;
   logic [NUM_HARTS-1:0]  r_overflow;
   logic [NUM_HARTS-1:0][DROP_W-1:0] r_drop_cnt;

   // One FIFO per hart.
   for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
      cosim_commit_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (w_push[g]),
         .pop_i   (w_pop[g]),
         .entry_i (w_entry[g]),
         .full_o  (w_full[g]),
         .empty_o (w_empty[g]),
         .count_o (occupancy_o[g]),
         .head_o  (w_head[g])
      );
   end

   // Round-robin search from the pointer: first non-empty hart wins.
   always_comb begin
      int idx;
      w_any   = 1'b0;
      w_grant = '0;
      idx     = 0;
      for (int i = 0; i < NUM_HARTS; i++) begin
         idx = int'(r_rr_ptr) + i;
         if (idx >= NUM_HARTS) idx = idx - NUM_HARTS;
         if (!w_any && !w_empty[idx]) begin
            w_any   = 1'b1;
            w_grant = HART_W'(idx);
         end
      end
      w_load = (!r_chk_valid || chk_ready_i) && w_any;
   end

   // Per-hart push/pop/drop decisions; a full FIFO still accepts a push
   // when it is popped in the same cycle.
   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         w_entry[h].rec = commit_i[h];
         w_entry[h].seq = r_seq_cnt[h];
         w_pop[h]  = w_load && (w_grant == HART_W'(h));
         w_push[h] = commit_valid_i[h] && (!w_full[h] || w_pop[h]);
         w_drop[h] = commit_valid_i[h] && w_full[h] && !w_pop[h];
      end
   end

   // Sequence numbering and overflow accounting; a drop beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int h = 0; h < NUM_HARTS; h++) r_seq_cnt[h] <= '0;
         r_overflow <= '0;
         r_drop_cnt <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (commit_valid_i[h]) r_seq_cnt[h] <= r_seq_cnt[h] + SEQ_W'(1);
            if (w_drop[h]) begin
               r_overflow[h] <= 1'b1;
               if (ovf_clr_i)
                  r_drop_cnt[h] <= DROP_W'(1);
               else if (r_drop_cnt[h] != '1)
                  r_drop_cnt[h] <= r_drop_cnt[h] + DROP_W'(1);
            end else if (ovf_clr_i) begin
               r_overflow[h] <= 1'b0;
               r_drop_cnt[h] <= '0;
            end
         end
      end
   end

   // Checker output register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk_valid <= 1'b0;
         r_chk_hart  <= '0;
         r_chk_rec   <= '0;
         r_rr_ptr    <= '0;
      end else if (w_load) begin
         r_chk_valid <= 1'b1;
         r_chk_hart  <= w_grant;
         r_chk_rec   <= w_head[w_grant];
         if (w_grant == HART_W'(NUM_HARTS - 1))
            r_rr_ptr <= '0;
         else
            r_rr_ptr <= w_grant + HART_W'(1);
      end else if (chk_ready_i) begin
         r_chk_valid <= 1'b0;
      end
   end

   assign chk_valid_o = r_chk_valid;
   assign chk_hart_o  = r_chk_hart;
   assign chk_rec_o   = r_chk_rec;
   assign overflow_o  = r_overflow;
   assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// Directed bench for cosim_commit_arbiter (2 harts, depth 8). Per-cycle
// vector tables cover latency, arbitration order, overflow and clear;
// hand-written sequences cover stall stability and mid-burst reset.
module tb_cosim_commit_arbiter;
   import cosim_pkg::*;

   localparam int NH = 2;
   localparam int DP = 8;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NH-1:0]           commit_valid_i = '0;
   commit_in_t [NH-1:0]     commit_i = '0;
   logic                    chk_valid_o;
   logic                    chk_ready_i = 1'b0;
   logic [0:0]              chk_hart_o;
   commit_entry_t           chk_rec_o;
   logic                    ovf_clr_i = 1'b0;
   logic [NH-1:0]           overflow_o;
   logic [NH-1:0][15:0]     drop_cnt_o;
   logic [NH-1:0][3:0]      occupancy_o;

   cosim_commit_arbiter #(
      .NUM_HARTS (NH),
      .DEPTH     (DP),
      .XLEN      (64),
      .SEQ_W     (32),
      .DROP_W    (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .commit_valid_i (commit_valid_i),
      .commit_i       (commit_i),
      .chk_valid_o    (chk_valid_o),
      .chk_ready_i    (chk_ready_i),
      .chk_hart_o     (chk_hart_o),
      .chk_rec_o      (chk_rec_o),
      .ovf_clr_i      (ovf_clr_i),
      .overflow_o     (overflow_o),
      .drop_cnt_o     (drop_cnt_o),
      .occupancy_o    (occupancy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] v;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic       eh;
      int         es;
      logic [1:0] eovf;
      int         ed0;
      int         ed1;
      int         eo0;
      int         eo1;
   } vec_t;

   vec_t tbl[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   sent [NH];

   function automatic logic [63:0] exp_pc(input int h, input int seq);
      return 64'h8000_0000 + 64'(h) * 64'h1000 + 64'(4 * seq);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [1:0] v, input logic rdy, input logic clr,
                               input logic ev, input logic eh, input int es,
                               input logic [1:0] eovf, input int ed0, input int ed1,
                               input int eo0, input int eo1);
      vec_t t;
      t.v = v; t.rdy = rdy; t.clr = clr; t.ev = ev; t.eh = eh; t.es = es;
      t.eovf = eovf; t.ed0 = ed0; t.ed1 = ed1; t.eo0 = eo0; t.eo1 = eo1;
      tbl.push_back(t);
   endfunction

   // Apply one cycle of inputs, clock it, and return #1 after the edge.
   task automatic drive(input logic [1:0] v, input logic rdy, input logic clr);
      commit_in_t c;
      for (int h = 0; h < NH; h++) begin
         c          = '0;
         c.pc       = exp_pc(h, sent[h]);
         c.ins      = 32'(sent[h]);
         c.dst      = 5'(h + 1);
         c.wr_valid = 1'b1;
         c.data     = 64'hD000 + 64'(sent[h]);
         commit_i[h] = c;
      end
      commit_valid_i = v;
      chk_ready_i    = rdy;
      ovf_clr_i      = clr;
      @(posedge clk);
      for (int h = 0; h < NH; h++) if (v[h]) sent[h]++;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      commit_valid_i = '0;
      chk_ready_i = 1'b0;
      ovf_clr_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int h = 0; h < NH; h++) sent[h] = 0;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("%s[%0d] valid", tag, i), 64'(chk_valid_o), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk($sformatf("%s[%0d] hart", tag, i), 64'(chk_hart_o), 64'(tbl[i].eh));
            chk($sformatf("%s[%0d] seq", tag, i), 64'(chk_rec_o.seq), 64'(tbl[i].es));
            chk($sformatf("%s[%0d] pc", tag, i), chk_rec_o.rec.pc,
                exp_pc(int'(tbl[i].eh), tbl[i].es));
         end
         chk($sformatf("%s[%0d] ovf", tag, i), 64'(overflow_o), 64'(tbl[i].eovf));
         chk($sformatf("%s[%0d] drop0", tag, i), 64'(drop_cnt_o[0]), 64'(tbl[i].ed0));
         chk($sformatf("%s[%0d] drop1", tag, i), 64'(drop_cnt_o[1]), 64'(tbl[i].ed1));
         chk($sformatf("%s[%0d] occ0", tag, i), 64'(occupancy_o[0]), 64'(tbl[i].eo0));
         chk($sformatf("%s[%0d] occ1", tag, i), 64'(occupancy_o[1]), 64'(tbl[i].eo1));
      end
      tbl.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          pv;
      logic          prdy;
      logic [0:0]    phart;
      commit_entry_t prec;
      int            exp_seq;
      int            pushed;
      logic [1:0]    v;
      logic          rdy;

      for (int h = 0; h < NH; h++) sent[h] = 0;

      // Reset state
      do_reset();
      chk("rst valid", 64'(chk_valid_o), 64'd0);
      chk("rst hart", 64'(chk_hart_o), 64'd0);
      chk("rst rec_pc", chk_rec_o.rec.pc, 64'd0);
      chk("rst rec_seq", 64'(chk_rec_o.seq), 64'd0);
      chk("rst ovf", 64'(overflow_o), 64'd0);
      chk("rst drop", 64'(drop_cnt_o), 64'd0);
      chk("rst occ", 64'(occupancy_o), 64'd0);

      // Single hart-0 commit: FIFO holds it, next cycle it is on the port.
      //   v     rdy   clr   ev    eh    es ovf    d0 d1 o0 o1
      add(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0, 1, 0);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2'b00, 0, 0, 0, 0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0, 0, 0);
      run_table("single");

      // Both harts push 3 records together: order 0,1,0,1,0,1.
      do_reset();
      add(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0, 1, 1);
      add(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2'b00, 0, 0, 1, 2);
      add(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 0, 2'b00, 0, 0, 2, 2);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2'b00, 0, 0, 1, 2);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1, 2'b00, 0, 0, 1, 1);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2'b00, 0, 0, 0, 1);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2, 2'b00, 0, 0, 0, 0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0, 0, 0);
      run_table("rr");

      // Hart 1 overflow with ready low, clear vs drop, full push+pop, drain.
      do_reset();
      add(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0, 0, 1);
      add(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2'b00, 0, 0, 0, 1);
      for (int k = 2; k <= 8; k++)
         add(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2'b00, 0, 0, 0, k);
      add(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2'b10, 0, 1, 0, 8);
      add(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2'b10, 0, 2, 0, 8);
      add(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2'b10, 0, 1, 0, 8);
      add(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2'b00, 0, 0, 0, 8);
      add(2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1, 2'b00, 0, 0, 0, 8);
      for (int k = 2; k <= 8; k++)
         add(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, k, 2'b00, 0, 0, 0, 9 - k);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 12, 2'b00, 0, 0, 0, 0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0, 0, 0);
      run_table("ovf");

      // Ready toggling with hart-0 pushes: stalled record holds, no loss/dup.
      do_reset();
      exp_seq = 0;
      pushed  = 0;
      for (int c = 0; c < 52; c++) begin
         pv    = chk_valid_o;
         phart = chk_hart_o;
         prec  = chk_rec_o;
         v     = (c < 40 && (c % 2 == 0)) ? 2'b01 : 2'b00;
         rdy   = (c >= 40) ? 1'b1 : ((c % 2) == 1);
         if (v[0]) pushed++;
         prdy  = rdy;
         drive(v, rdy, 1'b0);
         if (pv && !prdy) begin
            chk($sformatf("stall[%0d] valid", c), 64'(chk_valid_o), 64'd1);
            chk($sformatf("stall[%0d] hart", c), 64'(chk_hart_o), 64'(phart));
            chk($sformatf("stall[%0d] seq", c), 64'(chk_rec_o.seq), 64'(prec.seq));
            chk($sformatf("stall[%0d] pc", c), chk_rec_o.rec.pc, prec.rec.pc);
         end
         if (pv && prdy) begin
            chk($sformatf("toggle[%0d] seq", c), 64'(prec.seq), 64'(exp_seq));
            chk($sformatf("toggle[%0d] pc", c), prec.rec.pc, exp_pc(0, exp_seq));
            exp_seq++;
         end
      end
      chk("toggle consumed", 64'(exp_seq), 64'(pushed));
      chk("toggle drops", 64'(drop_cnt_o[0]), 64'd0);
      chk("toggle tail valid", 64'(chk_valid_o), 64'd0);

      // Reset mid-burst with 5 entries buffered and one in the output register.
      do_reset();
      repeat (6) drive(2'b01, 1'b0, 1'b0);
      chk("burst occ0", 64'(occupancy_o[0]), 64'd5);
      chk("burst valid", 64'(chk_valid_o), 64'd1);
      commit_valid_i = '0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst valid", 64'(chk_valid_o), 64'd0);
      chk("midrst hart", 64'(chk_hart_o), 64'd0);
      chk("midrst rec_pc", chk_rec_o.rec.pc, 64'd0);
      chk("midrst rec_seq", 64'(chk_rec_o.seq), 64'd0);
      chk("midrst occ", 64'(occupancy_o), 64'd0);
      chk("midrst ovf", 64'(overflow_o), 64'd0);
      rst = 1'b0;
      for (int h = 0; h < NH; h++) sent[h] = 0;
      drive(2'b01, 1'b1, 1'b0);
      drive(2'b00, 1'b1, 1'b0);
      chk("postrst valid", 64'(chk_valid_o), 64'd1);
      chk("postrst hart", 64'(chk_hart_o), 64'd0);
      chk("postrst seq", 64'(chk_rec_o.seq), 64'd0);
      chk("postrst pc", chk_rec_o.rec.pc, exp_pc(0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
